// File: rtl/larpix_cfg_pkg.sv
// Shared types for the configuration register path: arbiter FSM states and the
// per-requester access descriptor.
package larpix_cfg_pkg;

    localparam int CFG_ADDR_W = 8;
    localparam int CFG_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RWAIT,
        DFLT
    } cfg_arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] wdata;
    } cfg_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from req[1:0]; on a tie the requester
// not granted last wins. The history only advances when the grant is accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1 when requester 1 (B) held the most recent accepted grant
    logic last_1;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_1 <= 1'b0;
        end else if (accept && (grant != 2'b00)) begin
            last_1 <= grant[1];
        end
    end

endmodule

// File: rtl/config_access_arbiter.sv
// Sole master of the 256x8 config regfile: serialises single-byte accesses from A (comms)
// and B (sequencer) and default reloads. Define CFG_ARB_WRITE_PROTECT_EN to reject B writes >= PROTECT_LO.
module config_access_arbiter
    import larpix_cfg_pkg::*;
#(
    parameter int              ADDR_W     = CFG_ADDR_W,
    parameter int              DATA_W     = CFG_DATA_W,
    parameter logic [ADDR_W-1:0] PROTECT_LO = 8'hF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              err_b,
    input  logic              defaults_req,
    output logic              cfg_write,
    output logic [ADDR_W-1:0] cfg_write_addr,
    output logic [DATA_W-1:0] cfg_write_data,
    output logic              cfg_read,
    output logic [ADDR_W-1:0] cfg_read_addr,
    output logic              cfg_load_defaults,
    input  logic [DATA_W-1:0] cfg_read_data,
    output logic              busy
);

`ifdef CFG_ARB_WRITE_PROTECT_EN
    localparam bit PROTECT_EN = 1'b1;
`else
    localparam bit PROTECT_EN = 1'b0;
`endif

    cfg_arb_state_t state, state_nxt;
    cfg_req_t       req_a_s, req_b_s, win;
    logic [1:0]     grant;
    logic           accept, pick_b, blocked;
    logic           owner_b;
    logic           gnt_a_nxt, gnt_b_nxt, write_nxt, read_nxt, dflt_nxt, err_nxt;
    logic           rvalid_a_nxt, rvalid_b_nxt;

    assign req_a_s = {we_a, addr_a, wdata_a};
    assign req_b_s = {we_b, addr_b, wdata_b};

    // Defaults reload outranks both requesters, so the arbiter only accepts when it is idle
    assign accept  = (state == IDLE) && !defaults_req && (req_a || req_b);
    assign pick_b  = grant[1];
    assign win     = pick_b ? req_b_s : req_a_s;
    assign blocked = PROTECT_EN && pick_b && win.we && (win.addr >= PROTECT_LO);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({req_b, req_a}),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_a_nxt    = 1'b0;
        gnt_b_nxt    = 1'b0;
        write_nxt    = 1'b0;
        read_nxt     = 1'b0;
        dflt_nxt     = 1'b0;
        err_nxt      = 1'b0;
        rvalid_a_nxt = 1'b0;
        rvalid_b_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (defaults_req) begin
                    state_nxt = DFLT;
                    dflt_nxt  = 1'b1;
                end else if (accept) begin
                    gnt_a_nxt = grant[0];
                    gnt_b_nxt = grant[1];
                    if (win.we) begin
                        state_nxt = WRITE;
                        write_nxt = !blocked;
                        err_nxt   = blocked;
                    end else begin
                        state_nxt = READ;
                        read_nxt  = 1'b1;
                    end
                end
            end
            WRITE:   state_nxt = IDLE;
            DFLT:    state_nxt = IDLE;
            READ:    state_nxt = RWAIT;
            RWAIT: begin
                state_nxt    = IDLE;
                rvalid_a_nxt = !owner_b;
                rvalid_b_nxt = owner_b;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is registered; the regfile returns read data one cycle after cfg_read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_a             <= 1'b0;
            gnt_b             <= 1'b0;
            rvalid_a          <= 1'b0;
            rvalid_b          <= 1'b0;
            err_b             <= 1'b0;
            cfg_write         <= 1'b0;
            cfg_read          <= 1'b0;
            cfg_load_defaults <= 1'b0;
            busy              <= 1'b0;
            owner_b           <= 1'b0;
            rdata_a           <= '0;
            rdata_b           <= '0;
            cfg_write_addr    <= '0;
            cfg_write_data    <= '0;
            cfg_read_addr     <= '0;
        end else begin
            gnt_a             <= gnt_a_nxt;
            gnt_b             <= gnt_b_nxt;
            rvalid_a          <= rvalid_a_nxt;
            rvalid_b          <= rvalid_b_nxt;
            err_b             <= err_nxt;
            cfg_write         <= write_nxt;
            cfg_read          <= read_nxt;
            cfg_load_defaults <= dflt_nxt;
            busy              <= (state_nxt != IDLE);
            if (write_nxt) begin
                cfg_write_addr <= win.addr;
                cfg_write_data <= win.wdata;
            end
            if (read_nxt) begin
                cfg_read_addr <= win.addr;
                owner_b       <= pick_b;
            end
            if (rvalid_a_nxt) rdata_a <= cfg_read_data;
            if (rvalid_b_nxt) rdata_b <= cfg_read_data;
        end
    end

endmodule

// File: tb/tb_config_access_arbiter.sv
// Bench for config_access_arbiter: directed and random A/B/defaults traffic, a regfile
// stand-in, a transaction-level reference model and a scoreboarded output monitor.
module tb_config_access_arbiter;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         gap;
    } op_t;

    // strb bits: 7 gnt_a, 6 gnt_b, 5 cfg_write, 4 cfg_read, 3 load_defaults, 2 rvalid_a, 1 rvalid_b, 0 err_b
    typedef struct {
        int         cyc;
        logic [7:0] strb;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] ra;
        logic [7:0] rb;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a, we_a, req_b, we_b, defaults_req;
    logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, err_b;
    logic [7:0] rdata_a, rdata_b;
    logic       cfg_write, cfg_read, cfg_load_defaults, busy;
    logic [7:0] cfg_write_addr, cfg_write_data, cfg_read_addr, cfg_read_data;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  next_arb = 0;
    bit  last_b = 1'b0;
    bit  jitter = 1'b0;
    logic m_gnt_a = 1'b0, m_gnt_b = 1'b0;
    bit  have_a = 1'b0, have_b = 1'b0;
    int  dly_a = 0, dly_b = 0;
    logic [7:0] exp_ra = 8'h00, exp_rb = 8'h00;
    logic [7:0] mm [256];
    logic [7:0] rf [256];
    op_t qa[$];
    op_t qb[$];
    ev_t sbq[$];

    always #5 clk = ~clk;

    config_access_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .req_a             (req_a),
        .we_a              (we_a),
        .addr_a            (addr_a),
        .wdata_a           (wdata_a),
        .req_b             (req_b),
        .we_b              (we_b),
        .addr_b            (addr_b),
        .wdata_b           (wdata_b),
        .gnt_a             (gnt_a),
        .gnt_b             (gnt_b),
        .rvalid_a          (rvalid_a),
        .rvalid_b          (rvalid_b),
        .rdata_a           (rdata_a),
        .rdata_b           (rdata_b),
        .err_b             (err_b),
        .defaults_req      (defaults_req),
        .cfg_write         (cfg_write),
        .cfg_write_addr    (cfg_write_addr),
        .cfg_write_data    (cfg_write_data),
        .cfg_read          (cfg_read),
        .cfg_read_addr     (cfg_read_addr),
        .cfg_load_defaults (cfg_load_defaults),
        .cfg_read_data     (cfg_read_data),
        .busy              (busy)
    );

    function automatic logic [7:0] dflt_val(input logic [7:0] a);
        return a ^ 8'h3C;
    endfunction

    function automatic logic [7:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return 8'hF0;
            1:       return 8'hEF;
            2:       return 8'hFF;
            3:       return 8'h00;
            4:       return 8'($urandom);
            default: return 8'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.we    = 1'($urandom);
        o.addr  = rnd_addr();
        o.wdata = 8'($urandom);
        o.gap   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Regfile stand-in: registered read data, write and default load on the clock edge
    initial begin
        for (int i = 0; i < 256; i++) rf[i] <= dflt_val(8'(i));
        cfg_read_data <= 8'h00;
        forever begin
            @(posedge clk);
            if (cfg_load_defaults) for (int i = 0; i < 256; i++) rf[i] <= dflt_val(8'(i));
            if (cfg_write) rf[cfg_write_addr] <= cfg_write_data;
            if (cfg_read) cfg_read_data <= rf[cfg_read_addr];
        end
    end

    // Reference model: one arbitration decision per eligible edge, expressed as
    // fixed latencies (write 2, read 3, defaults 2 cycles between decisions)
    initial begin
        bit         b_wins, blocked;
        logic [7:0] a, d;
        logic       w;
        ev_t        e;
        for (int i = 0; i < 256; i++) mm[i] = dflt_val(8'(i));
        forever begin
            @(posedge clk);
            cyc++;
            m_gnt_a = 1'b0;
            m_gnt_b = 1'b0;
            if (reset) begin
                sbq.delete();
                next_arb = cyc + 1;
                last_b   = 1'b0;
                exp_ra   = 8'h00;
                exp_rb   = 8'h00;
            end else if (cyc >= next_arb) begin
                if (defaults_req) begin
                    e = '{cyc, 8'b0000_1000, 8'h00, 8'h00, exp_ra, exp_rb};
                    sbq.push_back(e);
                    for (int i = 0; i < 256; i++) mm[i] = dflt_val(8'(i));
                    next_arb = cyc + 2;
                end else if (req_a || req_b) begin
                    b_wins = (req_a && req_b) ? !last_b : req_b;
                    last_b = b_wins;
                    w = b_wins ? we_b : we_a;
                    a = b_wins ? addr_b : addr_a;
                    d = b_wins ? wdata_b : wdata_a;
                    m_gnt_a = !b_wins;
                    m_gnt_b = b_wins;
                    if (w) begin
`ifdef CFG_ARB_WRITE_PROTECT_EN
                        blocked = b_wins && (a >= 8'hF0);
`else
                        blocked = 1'b0;
`endif
                        e = '{cyc, {!b_wins, b_wins, !blocked, 4'b0000, blocked}, a, d, exp_ra, exp_rb};
                        sbq.push_back(e);
                        if (!blocked) mm[a] = d;
                        next_arb = cyc + 2;
                    end else begin
                        e = '{cyc, {!b_wins, b_wins, 6'b01_0000}, a, 8'h00, exp_ra, exp_rb};
                        sbq.push_back(e);
                        if (b_wins) exp_rb = mm[a];
                        else        exp_ra = mm[a];
                        e = '{cyc + 2, {5'b00000, !b_wins, b_wins, 1'b0}, a, 8'h00, exp_ra, exp_rb};
                        sbq.push_back(e);
                        next_arb = cyc + 3;
                    end
                end
            end
        end
    end

    // Monitor: every output event must match the front of the scoreboard
    initial begin
        logic [7:0] obs;
        ev_t        e;
        forever begin
            @(negedge clk);
            if (reset) continue;
            obs = {gnt_a, gnt_b, cfg_write, cfg_read, cfg_load_defaults, rvalid_a, rvalid_b, err_b};
            chk("busy", busy, (cyc + 1 < next_arb));
            if (obs != 8'h00) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_event", obs, 8'h00);
                end else begin
                    e = sbq.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_strobes", obs, e.strb);
                    if (e.strb[5]) chk("cfg_write_addr_data", {cfg_write_addr, cfg_write_data}, {e.addr, e.data});
                    if (e.strb[4]) chk("cfg_read_addr", cfg_read_addr, e.addr);
                    if (e.strb[2] || e.strb[1]) chk("rdata_a_b", {rdata_a, rdata_b}, {e.ra, e.rb});
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                chk("missed_event", obs, e.strb);
            end
        end
    end

    // Requester drivers: hold req until the model's grant, then drop it
    initial begin
        op_t op;
        req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
        forever begin
            @(posedge clk); #2;
            if (reset || m_gnt_a) begin
                req_a = 1'b0; have_a = 1'b0;
            end else if (!req_a) begin
                if (have_a) begin
                    if (dly_a > 0) dly_a--; else req_a = 1'b1;
                end else if (qa.size() > 0) begin
                    op = qa.pop_front();
                    we_a = op.we; addr_a = op.addr; wdata_a = op.wdata;
                    have_a = 1'b1; dly_a = op.gap;
                    if (op.gap == 0) req_a = 1'b1;
                end
            end else if (jitter && $urandom_range(0, 5) == 0) begin
                we_a = 1'($urandom); addr_a = rnd_addr(); wdata_a = 8'($urandom);
            end
        end
    end

    initial begin
        op_t op;
        req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;
        forever begin
            @(posedge clk); #2;
            if (reset || m_gnt_b) begin
                req_b = 1'b0; have_b = 1'b0;
            end else if (!req_b) begin
                if (have_b) begin
                    if (dly_b > 0) dly_b--; else req_b = 1'b1;
                end else if (qb.size() > 0) begin
                    op = qb.pop_front();
                    we_b = op.we; addr_b = op.addr; wdata_b = op.wdata;
                    have_b = 1'b1; dly_b = op.gap;
                    if (op.gap == 0) req_b = 1'b1;
                end
            end else if (jitter && $urandom_range(0, 5) == 0) begin
                we_b = 1'($urandom); addr_b = rnd_addr(); wdata_b = 8'($urandom);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || have_a || have_b || req_a || req_b
                || sbq.size() > 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain: timeout after %0d cycles with %0d events pending", n, sbq.size());
        end
    endtask

    initial begin
        int dhold = 0;
        int rv_seen = 0;
        int n = 0;
        defaults_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", {gnt_a, gnt_b, rvalid_a, rvalid_b, err_b, cfg_write, cfg_read,
                              cfg_load_defaults, busy}, 0);
        chk("reset_rdata", {rdata_a, rdata_b}, 0);
        chk("reset_cfg_bus", {cfg_write_addr, cfg_write_data, cfg_read_addr}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Simultaneous A/B requests straight after reset: B first, then strict alternation
        @(posedge clk); #1;
        qa.push_back('{1'b1, 8'h20, 8'h11, 0});
        qb.push_back('{1'b1, 8'h21, 8'h22, 0});
        qa.push_back('{1'b1, 8'h22, 8'h33, 0});
        qb.push_back('{1'b1, 8'h23, 8'h44, 0});
        qa.push_back('{1'b0, 8'h21, 8'h00, 0});
        qb.push_back('{1'b0, 8'h20, 8'h00, 0});
        drain();

        // Lone A write, then lone B read of the same register
        qa.push_back('{1'b1, 8'h12, 8'h5A, 0});
        drain();
        qb.push_back('{1'b0, 8'h12, 8'h00, 0});
        drain();

        // Defaults request and A request on the same edge
        @(posedge clk); #1;
        qa.push_back('{1'b1, 8'h30, 8'hC3, 0});
        #2;
        defaults_req = 1'b1;
        @(posedge clk); #3;
        defaults_req = 1'b0;
        drain();
        qa.push_back('{1'b0, 8'h30, 8'h00, 0});
        qb.push_back('{1'b0, 8'h12, 8'h00, 0});
        drain();

        // B writes around the protected boundary, then read both back
        qb.push_back('{1'b1, 8'hF5, 8'h77, 0});
        qb.push_back('{1'b1, 8'hEF, 8'h88, 0});
        qb.push_back('{1'b0, 8'hF5, 8'h00, 0});
        qb.push_back('{1'b0, 8'hEF, 8'h00, 0});
        drain();

        // Random traffic with defaults pulses and occasional held levels
        jitter = 1'b1;
        for (int i = 0; i < 150; i++) begin
            qa.push_back(rnd_op());
            qb.push_back(rnd_op());
        end
        for (int c = 0; c < 1500 && (qa.size() > 0 || qb.size() > 0); c++) begin
            @(posedge clk); #3;
            if (defaults_req) begin
                if (dhold > 0) dhold--; else defaults_req = 1'b0;
            end else if ($urandom_range(0, 60) == 0) begin
                defaults_req = 1'b1;
                dhold = ($urandom_range(0, 3) == 0) ? 6 : 0;
            end
        end
        defaults_req = 1'b0;
        jitter = 1'b0;
        drain();

        // Reset while a read waits for regfile data
        qa.push_back('{1'b0, 8'h05, 8'h00, 0});
        while (!m_gnt_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL read_grant_wait: no grant within %0d cycles", n);
        end
        @(posedge clk); #1;
        chk("rwait_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("async_reset_strobes", {gnt_a, gnt_b, rvalid_a, rvalid_b, err_b, cfg_write, cfg_read,
                                    cfg_load_defaults, busy}, 0);
        chk("async_reset_rdata", {rdata_a, rdata_b}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rvalid_a || rvalid_b) rv_seen++;
        end
        chk("no_rvalid_after_reset", rv_seen, 0);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
